spu_writeback_unit: RTL

//   Consumer end of the even/odd pipeline stage chain: takes the last-stage outputs of both

---
 rtl/spu_pkg.sv | 24 ++
 rtl/spu_scoreboard.sv | 54 +++++
 rtl/spu_writeback_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared widths, writeback entry struct and unit IDs for the SPU writeback slice.
package spu_pkg;
    localparam int DATA_W   = 128;
    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 128;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = 2**CNT_W - 1;

    typedef enum logic [2:0] {
        UNIT_FX1, UNIT_FX2, UNIT_BYTE, UNIT_FP, UNIT_PERM, UNIT_LS, UNIT_BR, UNIT_NONE
    } unit_id_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] result;
        logic [ADDR_W-1:0] rt;
        unit_id_e          unit_id;
        logic [2:0]        latency;
    } wb_entry_t;

    function automatic logic commits(wb_entry_t e);
        return e.we && e.latency == 3'd0;
    endfunction
endpackage

// File: rtl/spu_scoreboard.sv
// spu_scoreboard: per-register pending-write counters with saturating net-delta update and
// sticky over/underflow error; exposes the registered count of three query registers.
module spu_scoreboard
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc_v1,
    input  logic              i_inc_v2,
    input  logic [ADDR_W-1:0] i_inc_rt1,
    input  logic [ADDR_W-1:0] i_inc_rt2,
    input  logic              i_dec_v1,
    input  logic              i_dec_v2,
    input  logic [ADDR_W-1:0] i_dec_rt1,
    input  logic [ADDR_W-1:0] i_dec_rt2,
    input  logic [ADDR_W-1:0] i_query_rt [3],
    output logic [CNT_W-1:0]  o_query_cnt [3],
    output logic              o_err_count
);
    logic [CNT_W-1:0]    r_cnt  [NUM_REGS];
    logic [CNT_W-1:0]    w_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_bad;
    logic                r_err;

    // Net delta per register is summed first so issue+commit on one RT cancels cleanly.
    always_comb begin
        int s;
        s = 0;
        w_bad = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            s = int'(r_cnt[r])
              + int'(i_inc_v1 && i_inc_rt1 == ADDR_W'(r)) + int'(i_inc_v2 && i_inc_rt2 == ADDR_W'(r))
              - int'(i_dec_v1 && i_dec_rt1 == ADDR_W'(r)) - int'(i_dec_v2 && i_dec_rt2 == ADDR_W'(r));
            w_bad[r]  = s < 0 || s > CNT_MAX;
            w_next[r] = s < 0 ? '0 : s > CNT_MAX ? '1 : CNT_W'(s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_next[r];
            r_err <= r_err | (|w_bad);
        end
    end

    for (genvar q = 0; q < 3; q++) begin : g_query
        assign o_query_cnt[q] = r_cnt[i_query_rt[q]];
    end

    assign o_err_count = r_err;
endmodule

// File: rtl/spu_writeback_unit.sv
// spu_writeback_unit: commits zero-latency even/odd pipe results to two registered RF write
// ports and tracks pending writes. Optional SPU_WB_BYPASS_EN adds same-cycle result bypass.
module spu_writeback_unit
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              regWriteEnable_in1,
    input  logic              regWriteEnable_in2,
    input  logic [DATA_W-1:0] result_in1,
    input  logic [DATA_W-1:0] result_in2,
    input  logic [ADDR_W-1:0] registerRT_in1,
    input  logic [ADDR_W-1:0] registerRT_in2,
    input  logic [2:0]        unitID_in1,
    input  logic [2:0]        unitID_in2,
    input  logic [2:0]        latency_in1,
    input  logic [2:0]        latency_in2,
    input  logic              issue_valid1,
    input  logic              issue_valid2,
    input  logic [ADDR_W-1:0] issue_rt1,
    input  logic [ADDR_W-1:0] issue_rt2,
    input  logic [ADDR_W-1:0] query_rt0,
    input  logic [ADDR_W-1:0] query_rt1,
    input  logic [ADDR_W-1:0] query_rt2,
    output logic              query_busy0,
    output logic              query_busy1,
    output logic              query_busy2,
    output logic              rf_we1,
    output logic              rf_we2,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    output logic [DATA_W-1:0] rf_data1,
    output logic [DATA_W-1:0] rf_data2,
    output logic              err_collision,
    output logic              err_latency,
    output logic              err_count
`ifdef SPU_WB_BYPASS_EN
    ,
    output logic              byp_hit0,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data0,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2
`endif
);
    wb_entry_t         w_e1, w_e2;
    logic              w_c1, w_c2, w_coll, w_unused_uid;
    logic [ADDR_W-1:0] w_qrt  [3];
    logic [CNT_W-1:0]  w_qcnt [3];
    logic [2:0]        w_busy;
    logic              r_we1, r_we2, r_err_coll, r_err_lat;
    logic [ADDR_W-1:0] r_addr1, r_addr2;
    logic [DATA_W-1:0] r_data1, r_data2;

    assign w_e1 = '{regWriteEnable_in1, result_in1, registerRT_in1, unit_id_e'(unitID_in1), latency_in1};
    assign w_e2 = '{regWriteEnable_in2, result_in2, registerRT_in2, unit_id_e'(unitID_in2), latency_in2};
    assign w_unused_uid = ^{w_e1.unit_id, w_e2.unit_id};
    assign w_c1   = commits(w_e1);
    assign w_c2   = commits(w_e2);
    assign w_coll = w_c1 && w_c2 && w_e1.rt == w_e2.rt;
    assign w_qrt[0] = query_rt0;
    assign w_qrt[1] = query_rt1;
    assign w_qrt[2] = query_rt2;

    // Both commits decrement even on collision: both instructions retire.
    spu_scoreboard u_sb (
        .clk(clk), .reset(reset),
        .i_inc_v1(issue_valid1), .i_inc_v2(issue_valid2),
        .i_inc_rt1(issue_rt1), .i_inc_rt2(issue_rt2),
        .i_dec_v1(w_c1), .i_dec_v2(w_c2),
        .i_dec_rt1(w_e1.rt), .i_dec_rt2(w_e2.rt),
        .i_query_rt(w_qrt), .o_query_cnt(w_qcnt), .o_err_count(err_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we1 <= 1'b0;
            r_we2 <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_err_coll <= 1'b0;
            r_err_lat <= 1'b0;
        end else begin
            r_we1 <= w_c1;
            r_we2 <= w_c2 && !w_coll;
            r_addr1 <= w_c1 ? w_e1.rt : r_addr1;
            r_data1 <= w_c1 ? w_e1.result : r_data1;
            r_addr2 <= w_c2 ? w_e2.rt : r_addr2;
            r_data2 <= w_c2 ? w_e2.result : r_data2;
            r_err_coll <= r_err_coll | w_coll;
            r_err_lat <= r_err_lat | (w_e1.we && w_e1.latency != 3'd0) | (w_e2.we && w_e2.latency != 3'd0);
        end
    end

`ifdef SPU_WB_BYPASS_EN
    logic              w_hit [3];
    logic [DATA_W-1:0] w_byp [3];
    for (genvar n = 0; n < 3; n++) begin : g_byp
        logic       w_h1, w_h2;
        logic [1:0] w_hits;
        assign w_h1   = w_c1 && w_e1.rt == w_qrt[n];
        assign w_h2   = w_c2 && !w_coll && w_e2.rt == w_qrt[n];
        assign w_hits = {1'b0, w_h1} + {1'b0, w_c2 && w_e2.rt == w_qrt[n]};
        assign w_hit[n]  = w_h1 || w_h2;
        assign w_byp[n]  = w_h2 ? w_e2.result : w_e1.result;
        // Only clear busy when every pending write to this RT lands this cycle.
        assign w_busy[n] = w_qcnt[n] != '0 && !(w_hit[n] && w_qcnt[n] == CNT_W'(w_hits));
    end
    assign byp_hit0  = w_hit[0];
    assign byp_hit1  = w_hit[1];
    assign byp_hit2  = w_hit[2];
    assign byp_data0 = w_byp[0];
    assign byp_data1 = w_byp[1];
    assign byp_data2 = w_byp[2];
`else
    for (genvar n = 0; n < 3; n++) begin : g_busy
        assign w_busy[n] = w_qcnt[n] != '0;
    end
`endif

    assign query_busy0   = w_busy[0];
    assign query_busy1   = w_busy[1];
    assign query_busy2   = w_busy[2];
    assign rf_we1        = r_we1;
    assign rf_we2        = r_we2;
    assign rf_addr1      = r_addr1;
    assign rf_addr2      = r_addr2;
    assign rf_data1      = r_data1;
    assign rf_data2      = r_data2;
    assign err_collision = r_err_coll;
    assign err_latency   = r_err_lat;
endmodule
